// File: rtl/proc_control_fsm.sv
// Control unit for the 8-bit lab processor: fetches an instruction word from DIN
// and sequences mv / mvi / add / sub over time steps T0..T3.
module proc_control_fsm #(
  parameter int N     = 8,
  parameter int NREGS = 8,
  parameter int CW    = 8
) (
  input  logic             P_clock,
  input  logic             resetn,
  input  logic             Run,
  input  logic [N-1:0]     DIN,
  output logic             IRin,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic             DINout,
  output logic             Ain,
  output logic             Gin,
  output logic             Gout,
  output logic             AddSub,
  output logic             Done,
  output logic [1:0]       Tstep,
  output logic [CW-1:0]    instr_count
);

  typedef enum logic [1:0] {T0, T1, T2, T3} tstep_e;
  typedef enum logic [1:0] {OP_MV, OP_MVI, OP_ADD, OP_SUB} op_e;

  tstep_e          t_q, t_d;
  logic [N-1:0]    ir_q;
  logic [CW-1:0]   cnt_q;

  op_e             op;
  logic [2:0]      fx, fy;
  logic [NREGS-1:0] x_hot, y_hot;

  assign op    = op_e'(ir_q[1:0]);
  assign fx    = ir_q[4:2];
  assign fy    = ir_q[7:5];
  assign x_hot = NREGS'(1) << fx;
  assign y_hot = NREGS'(1) << fy;

  // Control outputs are decoded from the current step and IR, then forced low
  // during reset so nothing drives the bus while the datapath is being cleared.
  always_comb begin
    t_d    = t_q;
    IRin   = 1'b0;
    Rin    = '0;
    Rout   = '0;
    DINout = 1'b0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    Gout   = 1'b0;
    AddSub = 1'b0;
    Done   = 1'b0;
    case (t_q)
      T0: begin
        IRin = Run;
        if (Run) t_d = T1;
      end
      T1: begin
        case (op)
          OP_MV: begin
            Rout = y_hot;
            Rin  = x_hot;
            Done = 1'b1;
            t_d  = T0;
          end
          OP_MVI: begin
            DINout = 1'b1;
            Rin    = x_hot;
            Done   = 1'b1;
            t_d    = T0;
          end
          default: begin
            Rout = x_hot;
            Ain  = 1'b1;
            t_d  = T2;
          end
        endcase
      end
      T2: begin
        if (op == OP_ADD || op == OP_SUB) begin
          Rout   = y_hot;
          Gin    = 1'b1;
          AddSub = (op == OP_SUB);
          t_d    = T3;
        end else begin
          t_d = T0;
        end
      end
      default: begin
        if (op == OP_ADD || op == OP_SUB) begin
          Gout   = 1'b1;
          Rin    = x_hot;
          AddSub = (op == OP_SUB);
          Done   = 1'b1;
        end
        t_d = T0;
      end
    endcase
    if (resetn) begin
      IRin   = 1'b0;
      Rin    = '0;
      Rout   = '0;
      DINout = 1'b0;
      Ain    = 1'b0;
      Gin    = 1'b0;
      Gout   = 1'b0;
      AddSub = 1'b0;
      Done   = 1'b0;
    end
  end

  always_ff @(posedge P_clock or posedge resetn) begin
    if (resetn) begin
      t_q   <= T0;
      ir_q  <= '0;
      cnt_q <= '0;
    end else begin
      t_q <= t_d;
      if (IRin) ir_q <= DIN;
      if (Done) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign Tstep       = t_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_proc_control_fsm.sv
// Bench for proc_control_fsm: directed and random instruction streams checked
// against a per-opcode step table of expected control signals.
module tb_proc_control_fsm;

  logic       P_clock = 1'b0;
  logic       resetn  = 1'b1;
  logic       Run     = 1'b0;
  logic [7:0] DIN     = '0;
  logic       IRin, DINout, Ain, Gin, Gout, AddSub, Done;
  logic [7:0] Rin, Rout, instr_count;
  logic [1:0] Tstep;

  int checks = 0;
  int fails  = 0;
  logic [7:0] m_cnt = '0;

  proc_control_fsm #(.N(8), .NREGS(8), .CW(8)) dut (
    .P_clock(P_clock), .resetn(resetn), .Run(Run), .DIN(DIN),
    .IRin(IRin), .Rin(Rin), .Rout(Rout), .DINout(DINout), .Ain(Ain),
    .Gin(Gin), .Gout(Gout), .AddSub(AddSub), .Done(Done),
    .Tstep(Tstep), .instr_count(instr_count)
  );

  always #5 P_clock = ~P_clock;

  logic [32:0] obs;
  assign obs = {IRin, Rin, Rout, DINout, Ain, Gin, Gout, AddSub, Done, Tstep, instr_count};

  function automatic logic [32:0] mk(input logic irin, input logic [7:0] rin, input logic [7:0] rout,
                                     input logic dinout, input logic ain, input logic gin,
                                     input logic gout, input logic addsub, input logic done,
                                     input logic [1:0] ts, input logic [7:0] cnt);
    return {irin, rin, rout, dinout, ain, gin, gout, addsub, done, ts, cnt};
  endfunction

  // Executes one instruction from fetch to Done; the model is the opcode step table.
  task automatic run_instr(input logic [7:0] w, input logic hold_run, input string tag);
    logic [1:0]  op;
    logic [7:0]  xh, yh;
    int          nsteps;
    logic [32:0] e;
    op = w[1:0];
    xh = 8'(1 << w[4:2]);
    yh = 8'(1 << w[7:5]);
    nsteps = (op == 2'b00 || op == 2'b01) ? 1 : 3;
    @(negedge P_clock);
    Run = 1'b1;
    DIN = w;
    #1;
    checks++;
    if (obs !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, m_cnt)) begin
      fails++;
      $display("FAIL %s fetch: got %h required %h", tag, obs, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, m_cnt));
    end
    for (int k = 1; k <= nsteps; k++) begin
      @(negedge P_clock);
      Run = hold_run ? 1'b1 : 1'($urandom_range(0, 1));
      DIN = 8'($urandom);
      #1;
      if (op == 2'b00)      e = mk(0, xh, yh, 0, 0, 0, 0, 0, 1, 2'd1, m_cnt);
      else if (op == 2'b01) e = mk(0, xh, 0, 1, 0, 0, 0, 0, 1, 2'd1, m_cnt);
      else if (k == 1)      e = mk(0, 0, xh, 0, 1, 0, 0, 0, 0, 2'd1, m_cnt);
      else if (k == 2)      e = mk(0, 0, yh, 0, 0, 1, 0, op[0], 0, 2'd2, m_cnt);
      else                  e = mk(0, xh, 0, 0, 0, 0, 1, op[0], 1, 2'd3, m_cnt);
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL %s step T%0d (w=%h): got %h required %h", tag, k, w, obs, e);
      end
      checks++;
      if ((32'(Rout != 0) + 32'(DINout) + 32'(Gout)) > 1 || !$onehot0(Rin) || !$onehot0(Rout)) begin
        fails++;
        $display("FAIL %s bus_rule T%0d: got Rout=%h DINout=%b Gout=%b Rin=%h required single driver",
                 tag, k, Rout, DINout, Gout, Rin);
      end
    end
    m_cnt = m_cnt + 8'd1;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge P_clock);
      Run = 1'b0;
      DIN = 8'($urandom);
      #1;
      checks++;
      if (obs !== mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, m_cnt)) begin
        fails++;
        $display("FAIL %s idle: got %h required %h", tag, obs, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, m_cnt));
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge P_clock);
      Run = 1'($urandom_range(0, 1));
      DIN = 8'($urandom);
      #1;
      checks++;
      if (obs !== 33'd0) begin
        fails++;
        $display("FAIL reset_hold: got %h required %h", obs, 33'd0);
      end
    end
    @(negedge P_clock);
    resetn = 1'b0;
    Run = 1'b0;
    m_cnt = '0;
    idle(5, "reset_release");
  endtask

  task automatic test_directed();
    run_instr(8'h01, 1'b0, "mvi_r0");
    run_instr(8'h04, 1'b0, "mv_r1_r0");
    run_instr(8'h22, 1'b0, "add_r0_r1");
    run_instr(8'h6B, 1'b0, "sub_r2_r3");
    run_instr(8'h00, 1'b0, "mv_r0_r0");
    run_instr(8'hFC, 1'b0, "mv_r7_r7");
    idle(2, "directed_tail");
  endtask

  task automatic test_back_to_back();
    run_instr(8'h6B, 1'b1, "b2b_sub");
    run_instr(8'h05, 1'b1, "b2b_mvi");
    run_instr(8'h22, 1'b1, "b2b_add");
    run_instr(8'h24, 1'b1, "b2b_mv");
    idle(1, "b2b_tail");
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      run_instr(8'($urandom), 1'($urandom_range(0, 1)), "random");
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)), "random_gap");
    end
  endtask

  task automatic test_reset_mid();
    @(negedge P_clock);
    Run = 1'b1;
    DIN = 8'h22;
    @(negedge P_clock);
    Run = 1'b0;
    @(negedge P_clock);
    #1;
    checks++;
    if (obs !== mk(0, 0, 8'h02, 0, 0, 1, 0, 0, 0, 2'd2, m_cnt)) begin
      fails++;
      $display("FAIL reset_mid pre T2: got %h required %h", obs, mk(0, 0, 8'h02, 0, 0, 1, 0, 0, 0, 2'd2, m_cnt));
    end
    resetn = 1'b1;
    #1;
    m_cnt = '0;
    checks++;
    if (obs !== 33'd0) begin
      fails++;
      $display("FAIL reset_mid async: got %h required %h", obs, 33'd0);
    end
    @(negedge P_clock);
    resetn = 1'b0;
    idle(2, "reset_mid_wait");
    run_instr(8'h04, 1'b0, "reset_mid_mv");
    idle(1, "reset_mid_count");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish required finish before limit");
    $fatal(1);
  end

endmodule
